// File: rtl/attitude_pkg.sv
// Shared types and constants for the attitude sampling path.
package attitude_pkg;

  localparam int unsigned DEG_THRESHOLD = 15;
  localparam int unsigned ATT_W         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StReq,
    StEval
  } state_e;

endpackage

// File: rtl/Roll_Pitch_Encoder.sv
// Maps raw roll/pitch (1/16 deg LSB) to the 4-bit attitude code
// {sgn roll, sgn pitch, |roll| > threshold, |pitch| > threshold}.
module Roll_Pitch_Encoder
  import attitude_pkg::*;
(
  input  logic [15:0]      roll_raw_i,
  input  logic [15:0]      pitch_raw_i,
  output logic [ATT_W-1:0] code_o
);

  logic [15:0] roll_abs;
  logic [15:0] pitch_abs;

  always_comb begin
    // 0x8000 negates to itself, which still reads as a large magnitude.
    roll_abs  = roll_raw_i[15]  ? (~roll_raw_i + 16'd1)  : roll_raw_i;
    pitch_abs = pitch_raw_i[15] ? (~pitch_raw_i + 16'd1) : pitch_raw_i;
    code_o    = {roll_raw_i[15], pitch_raw_i[15],
                 (roll_abs >> 4) > 16'(DEG_THRESHOLD),
                 (pitch_abs >> 4) > 16'(DEG_THRESHOLD)};
  end

endmodule

// File: rtl/attitude_sample_scheduler.sv
// Periodically requests IMU samples, debounces the encoded attitude and
// flags acknowledge timeouts.
module attitude_sample_scheduler
  import attitude_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = 500000,
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Enable,
  output logic             o_Sample_Req,
  input  logic             i_Sample_Ack,
  input  logic [15:0]      i_Roll_Raw,
  input  logic [15:0]      i_Pitch_Raw,
  input  logic             i_Clear_Fault,
  output logic [ATT_W-1:0] o_Attitude,
  output logic             o_Attitude_Valid,
  output logic             o_Fault
);

  localparam int unsigned TickW = $clog2(SAMPLE_DIV + 1);
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned StbW  = $clog2(STABLE_COUNT + 1);
  localparam logic [TickW-1:0] TickReload = TickW'(SAMPLE_DIV - 1);

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [ToW-1:0]   to_q, to_d, to_inc;
  logic [StbW-1:0]  stable_q, stable_d;
  logic [ATT_W-1:0] prev_q, prev_d;
  logic [ATT_W-1:0] att_q, att_d;
  logic [15:0]      roll_q, roll_d, pitch_q, pitch_d;
  logic             req_q, req_d;
  logic             valid_q, valid_d;
  logic             fault_q, fault_d;
  logic             timeout;
  logic [ATT_W-1:0] cand;

  Roll_Pitch_Encoder u_encoder (
    .roll_raw_i  (roll_q),
    .pitch_raw_i (pitch_q),
    .code_o      (cand)
  );

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    to_d     = to_q;
    stable_d = stable_q;
    prev_d   = prev_q;
    att_d    = att_q;
    roll_d   = roll_q;
    pitch_d  = pitch_q;
    req_d    = 1'b0;
    valid_d  = 1'b0;
    timeout  = 1'b0;
    to_inc   = to_q + 1'b1;

    if (!i_Enable) begin
      state_d  = StIdle;
      tick_d   = TickReload;
      to_d     = '0;
      stable_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tick_d  = TickReload;
          state_d = StWait;
        end
        StWait: begin
          if (tick_q == '0) begin
            tick_d  = TickReload;
            to_d    = '0;
            req_d   = 1'b1;
            state_d = StReq;
          end else begin
            tick_d = tick_q - 1'b1;
          end
        end
        StReq: begin
          // Ack has priority over a timeout landing on the same edge.
          if (i_Sample_Ack) begin
            roll_d  = i_Roll_Raw;
            pitch_d = i_Pitch_Raw;
            to_d    = '0;
            state_d = StEval;
          end else if (to_inc == ToW'(TIMEOUT_CYCLES)) begin
            timeout = 1'b1;
            to_d    = '0;
            state_d = StWait;
          end else begin
            to_d  = to_inc;
            req_d = 1'b1;
          end
        end
        StEval: begin
          if (cand == prev_q) begin
            stable_d = (stable_q >= StbW'(STABLE_COUNT)) ? stable_q : stable_q + 1'b1;
          end else begin
            stable_d = StbW'(1);
          end
          prev_d = cand;
          if (stable_d == StbW'(STABLE_COUNT) && cand != att_q) begin
            att_d   = cand;
            valid_d = 1'b1;
          end
          state_d = StWait;
        end
        default: state_d = StIdle;
      endcase
    end

    fault_d = (fault_q & ~i_Clear_Fault) | timeout;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      to_q     <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      att_q    <= '0;
      roll_q   <= '0;
      pitch_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      to_q     <= to_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      att_q    <= att_d;
      roll_q   <= roll_d;
      pitch_q  <= pitch_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign o_Sample_Req     = req_q;
  assign o_Attitude       = att_q;
  assign o_Attitude_Valid = valid_q;
  assign o_Fault          = fault_q;

endmodule
